// File: rtl/spike_train_monitor.sv
// spike_train_monitor: hysteresis spike detector, inter-spike-interval FIFO and windowed rate counter
// Latency: spike/burst are registered one cycle after the spike sample; a pushed ISI is visible in that same cycle.
// Backpressure: isi_valid/isi_ready drain port; a push into a full FIFO without a pop is dropped and sets sticky overflow.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en, v_in            sample strobe and signed membrane sample (integer part of v)
//   spike               one-cycle pulse per detected spike
//   isi_valid/isi_data  FIFO head (isi_data is 0 while empty), popped by isi_ready
//   rate, rate_valid    spike count of the last completed WIN-sample window, update pulse
//   overflow, clr_ovf   sticky ISI-drop flag and its clear
//   burst               short-ISI flag, only with SPIKE_MON_BURST_EN defined (tied 0 otherwise)
module spike_train_monitor #(
  parameter int VW        = 8,
  parameter int TH_HI     = 25,
  parameter int TH_LO     = -40,
  parameter int ISI_W     = 12,
  parameter int WIN       = 256,
  parameter int DEPTH     = 4,
  parameter int BURST_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [VW-1:0] v_in,
  output logic                 spike,
  output logic                 isi_valid,
  output logic [ISI_W-1:0]     isi_data,
  input  logic                 isi_ready,
  output logic [7:0]           rate,
  output logic                 rate_valid,
  output logic                 overflow,
  input  logic                 clr_ovf,
  output logic                 burst
);

  localparam logic [0:0] ST_ARMED   = 1'b0;
  localparam logic [0:0] ST_REFRACT = 1'b1;

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;

  localparam logic signed [VW-1:0] TH_HI_V   = VW'(TH_HI);
  localparam logic signed [VW-1:0] TH_LO_V   = VW'(TH_LO);
  localparam logic [ISI_W-1:0]     ISI_MAX   = '1;
  localparam logic [CW-1:0]        FULL_CNT  = CW'(DEPTH);
  localparam logic [WCW-1:0]       WIN_LAST  = WCW'(WIN - 1);

  logic [0:0]       state;
  logic             first_seen;
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WCW-1:0]   win_cnt;
  logic [7:0]       spk_cnt;

  logic       spike_smp;
  logic       rearm;
  logic       push;
  logic       pop;
  logic       full;
  logic       push_ok;
  logic       drop;
  logic [8:0] spk_sum;
  logic [7:0] spk_next;

  // Detector: only an armed detector fires, only a refractory one re-arms.
  assign spike_smp = en && (state == ST_ARMED)   && (v_in >= TH_HI_V);
  assign rearm     = en && (state == ST_REFRACT) && (v_in <= TH_LO_V);

  // The very first spike has no predecessor, so it only starts the interval.
  assign push    = spike_smp && first_seen;
  assign pop     = isi_valid && isi_ready;
  assign full    = (count == FULL_CNT);
  // When full, a same-edge pop frees the head slot, which is exactly the slot wr_ptr points at.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign isi_valid = (count != '0);
  assign isi_data  = isi_valid ? mem[rd_ptr] : '0;

  // Spike count including the current sample, saturated to 8 bits.
  assign spk_sum  = {1'b0, spk_cnt} + 9'(spike_smp);
  assign spk_next = spk_sum[8] ? 8'hFF : spk_sum[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ARMED;
      first_seen <= 1'b0;
      isi_cnt    <= '0;
      spike      <= 1'b0;
    end else begin
      spike <= spike_smp;
      if (spike_smp) begin
        state      <= ST_REFRACT;
        first_seen <= 1'b1;
      end else if (rearm) begin
        state <= ST_ARMED;
      end
      // Counter holds the sample distance to the previous spike; a spike restarts it at 1
      // so that the next spike's value equals the index difference.
      if (spike_smp) begin
        isi_cnt <= ISI_W'(1);
      end else if (en && (isi_cnt != ISI_MAX)) begin
        isi_cnt <= isi_cnt + ISI_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= isi_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push_ok) begin
        count <= count - CW'(1);
      end
      // A fresh drop wins over a clear on the same edge.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt    <= '0;
      spk_cnt    <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (en) begin
        if (win_cnt == WIN_LAST) begin
          // A spike on the closing sample belongs to the closing window.
          rate       <= spk_next;
          rate_valid <= 1'b1;
          spk_cnt    <= '0;
          win_cnt    <= '0;
        end else begin
          spk_cnt <= spk_next;
          win_cnt <= win_cnt + WCW'(1);
        end
      end
    end
  end

`ifdef SPIKE_MON_BURST_EN
  localparam logic [ISI_W-1:0] BURST_LIM = ISI_W'(BURST_MAX);

  // Registered alongside spike, so it lines up with the pulse and the pushed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst <= 1'b0;
    end else begin
      burst <= push && (isi_cnt <= BURST_LIM);
    end
  end
`else
  assign burst = 1'b0;

  // BURST_MAX only matters in the burst build.
  logic unused_burst_cfg;
  assign unused_burst_cfg = (BURST_MAX != 0);
`endif

endmodule

// File: tb/tb_spike_train_monitor.sv
module tb_spike_train_monitor;

  localparam int VW = 8;
`ifdef SPIKE_MON_BURST_EN
  localparam logic EXP_B = 1'b1;
`else
  localparam logic EXP_B = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en = 1'b0;
  logic signed [VW-1:0] v_in = '0;
  logic                 spike;
  logic                 isi_valid;
  logic [11:0]          isi_data;
  logic                 isi_ready = 1'b0;
  logic [7:0]           rate;
  logic                 rate_valid;
  logic                 overflow;
  logic                 clr_ovf = 1'b0;
  logic                 burst;

  spike_train_monitor dut (
    .clk(clk), .rst(rst), .en(en), .v_in(v_in),
    .spike(spike), .isi_valid(isi_valid), .isi_data(isi_data), .isi_ready(isi_ready),
    .rate(rate), .rate_valid(rate_valid), .overflow(overflow), .clr_ovf(clr_ovf),
    .burst(burst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int got_q[$];
  int got_rd = 0;
  int spk_pulses = 0;

  // Scoreboard capture: a word leaves the DUT on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (!rst && isi_valid && isi_ready) got_q.push_back(int'(isi_data));
    if (spike) spk_pulses++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are applied 1 time unit after a posedge; return 1 unit after the edge that consumed them.
  task automatic step(input logic e, input int v);
    en = e;
    v_in = 8'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic spike_after(input int gap, input logic rdy, input logic clr);
    logic old_rdy;
    old_rdy = isi_ready;
    for (int i = 0; i < gap - 1; i++) step(1'b1, -65);
    isi_ready = rdy;
    clr_ovf = clr;
    step(1'b1, 30);
    isi_ready = old_rdy;
    clr_ovf = 1'b0;
  endtask

  task automatic sb_check(input string name);
    int e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_rd < got_q.size()) begin
        check(name, got_q[got_rd], e);
        got_rd++;
      end else begin
        check({name, "_missing"}, -1, e);
      end
    end
    check({name, "_extra"}, got_q.size() - got_rd, 0);
    got_rd = got_q.size();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    isi_ready = 1'b0;
    clr_ovf = 1'b0;
    step(1'b1, 30);
    step(1'b0, -65);
    rst = 1'b0;
    exp_q.delete();
    got_rd = got_q.size();
    check("rst_spike", spike, 0);
    check("rst_isi_valid", isi_valid, 0);
    check("rst_isi_data", isi_data, 0);
    check("rst_rate", rate, 0);
    check("rst_rate_valid", rate_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_burst", burst, 0);
  endtask

  typedef struct {
    logic en;
    int   v;
    logic exp_spike;
    logic exp_valid;
    int   exp_data;
    int   push_val;
  } vec_t;

  vec_t tbl[12];
  int   base;
  int   v;

  initial begin
    // Hysteresis / threshold-boundary vectors; outputs are those seen right after each edge.
    tbl[0]  = '{1'b1,  30, 1'b1, 1'b0, 0, 0};
    tbl[1]  = '{1'b1,  30, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b1,   0, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b1,  30, 1'b0, 1'b0, 0, 0};
    tbl[4]  = '{1'b1, -50, 1'b0, 1'b0, 0, 0};
    tbl[5]  = '{1'b1,  30, 1'b1, 1'b1, 5, 5};
    tbl[6]  = '{1'b0, -65, 1'b0, 1'b1, 5, 0};
    tbl[7]  = '{1'b1,  25, 1'b0, 1'b1, 5, 0};
    tbl[8]  = '{1'b1, -40, 1'b0, 1'b1, 5, 0};
    tbl[9]  = '{1'b1,  24, 1'b0, 1'b1, 5, 0};
    tbl[10] = '{1'b0,  25, 1'b0, 1'b1, 5, 0};
    tbl[11] = '{1'b1,  25, 1'b1, 1'b1, 5, 4};

    @(posedge clk);
    #1;

    // 1: periodic spikes every 10 samples over one full window
    do_reset();
    isi_ready = 1'b1;
    base = spk_pulses;
    for (int n = 0; n < 256; n++) begin
      v = (n % 10 == 0) ? 30 : -65;
      if (n % 10 == 0 && n > 0) exp_q.push_back(10);
      step(1'b1, v);
      check("t1_spike", spike, (n % 10 == 0) ? 1 : 0);
      if (n == 0) check("t1_first_no_push", isi_valid, 0);
      if (n == 10) begin
        check("t1_push_valid", isi_valid, 1);
        check("t1_push_data", isi_data, 10);
      end
      if (n == 254) check("t1_rv_early", rate_valid, 0);
      if (n == 255) begin
        check("t1_rv", rate_valid, 1);
        check("t1_rate", rate, 26);
      end
    end
    step(1'b0, -65);
    check("t1_rv_pulse", rate_valid, 0);
    check("t1_rate_hold", rate, 26);
    check("t1_pulses", spk_pulses - base, 26);
    sb_check("t1_isi");

    // 2: hysteresis table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].push_val != 0) exp_q.push_back(tbl[i].push_val);
      step(tbl[i].en, tbl[i].v);
      check($sformatf("t2_spike_%0d", i), spike, tbl[i].exp_spike);
      check($sformatf("t2_valid_%0d", i), isi_valid, tbl[i].exp_valid);
      check($sformatf("t2_data_%0d", i), isi_data, tbl[i].exp_data);
    end
    isi_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, -65);
    check("t2_drained", isi_valid, 0);
    sb_check("t2_isi");

    // 3: overflow with a stalled consumer, then drain and clear
    do_reset();
    for (int n = 0; n <= 20; n++) begin
      v = (n % 4 == 0) ? 30 : -65;
      if (n % 4 == 0 && n > 0 && n <= 16) exp_q.push_back(4);
      step(1'b1, v);
      if (n == 16) check("t3_ovf_before", overflow, 0);
      if (n == 20) check("t3_ovf_set", overflow, 1);
    end
    check("t3_full_valid", isi_valid, 1);
    check("t3_full_head", isi_data, 4);
    isi_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, -65);
    check("t3_empty", isi_valid, 0);
    step(1'b0, -65);
    check("t3_pop_empty", isi_valid, 0);
    check("t3_ovf_sticky", overflow, 1);
    isi_ready = 1'b0;
    clr_ovf = 1'b1;
    step(1'b0, -65);
    clr_ovf = 1'b0;
    check("t3_ovf_clr", overflow, 0);
    sb_check("t3_isi");

    // 4: drop racing a clear, then push+pop on a full FIFO
    do_reset();
    step(1'b1, 30);
    for (int g = 3; g <= 6; g++) begin
      exp_q.push_back(g);
      spike_after(g, 1'b0, 1'b0);
    end
    check("t4_ovf_full", overflow, 0);
    spike_after(7, 1'b0, 1'b1);
    check("t4_drop_beats_clr", overflow, 1);
    clr_ovf = 1'b1;
    step(1'b0, -65);
    clr_ovf = 1'b0;
    check("t4_ovf_clr", overflow, 0);
    exp_q.push_back(8);
    spike_after(8, 1'b1, 1'b0);
    check("t4_pp_ovf", overflow, 0);
    check("t4_pp_valid", isi_valid, 1);
    check("t4_pp_head", isi_data, 4);
    isi_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, -65);
    check("t4_count4", isi_valid, 0);
    sb_check("t4_isi");

    // 5: ISI saturation and en gating
    do_reset();
    isi_ready = 1'b1;
    base = spk_pulses;
    step(1'b1, 30);
    for (int i = 0; i < 5000; i++) begin
      step(1'b1, -65);
      step(1'b0, 30);
    end
    exp_q.push_back(4095);
    step(1'b1, 30);
    check("t5_sat_spike", spike, 1);
    check("t5_sat_data", isi_data, 4095);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, -65);
      step(1'b0, 30);
    end
    exp_q.push_back(8);
    step(1'b1, 30);
    check("t5_gate_spike", spike, 1);
    check("t5_gate_data", isi_data, 8);
    step(1'b0, -65);
    check("t5_pulses", spk_pulses - base, 3);
    sb_check("t5_isi");

    // 6: burst flag, then reset in mid-window
    do_reset();
    isi_ready = 1'b1;
    step(1'b1, 30);
    check("t6_burst_first", burst, 0);
    exp_q.push_back(6);
    spike_after(6, 1'b1, 1'b0);
    check("t6_spike6", spike, 1);
    check("t6_burst6", burst, EXP_B);
    exp_q.push_back(12);
    spike_after(12, 1'b1, 1'b0);
    check("t6_burst12", burst, 0);
    exp_q.push_back(8);
    spike_after(8, 1'b1, 1'b0);
    check("t6_burst8", burst, EXP_B);
    exp_q.push_back(9);
    spike_after(9, 1'b1, 1'b0);
    check("t6_burst9", burst, 0);
    step(1'b0, -65);
    check("t6_burst_pulse", burst, 0);
    sb_check("t6_isi");

    isi_ready = 1'b0;
    spike_after(4, 1'b0, 1'b0);
    check("t6_pre_rst_valid", isi_valid, 1);
    rst = 1'b1;
    step(1'b1, 30);
    rst = 1'b0;
    check("t6_rst_spike", spike, 0);
    check("t6_rst_valid", isi_valid, 0);
    check("t6_rst_data", isi_data, 0);
    check("t6_rst_rate", rate, 0);
    check("t6_rst_rv", rate_valid, 0);
    check("t6_rst_ovf", overflow, 0);
    check("t6_rst_burst", burst, 0);
    step(1'b1, 30);
    check("t6_rearmed_spike", spike, 1);
    check("t6_no_push", isi_valid, 0);
    for (int n = 1; n < 255; n++) step(1'b1, -65);
    check("t6_win_rv_early", rate_valid, 0);
    step(1'b1, -65);
    check("t6_win_rv", rate_valid, 1);
    check("t6_win_rate", rate, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
